// File: rtl/rob_queue_if.sv
// Reorder-buffer bundle: dispatch from rename, writeback from execute, commit/flush/occupancy out.
// Latency: none (signal container only).
// Backpressure: disp_ready_out gates dispatch; commit and flush are pulses with no ready.
interface rob_queue_if #(
    parameter int ROB_ENTRIES    = 128,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int WB_PORTS       = 2,
    parameter int ADDR_BITS      = 64,
    parameter int PREG_BITS      = 7
);
    localparam int IDX = $clog2(ROB_ENTRIES);

    // dispatch from rename
    logic [DISPATCH_WIDTH-1:0]           disp_valid_in;
    logic [DISPATCH_WIDTH*ADDR_BITS-1:0] disp_pc_in;
    logic [DISPATCH_WIDTH*PREG_BITS-1:0] disp_dest_in;
    logic [DISPATCH_WIDTH*PREG_BITS-1:0] disp_old_dest_in;
    logic                                disp_ready_out;
    logic [DISPATCH_WIDTH*IDX-1:0]       disp_ptr_out;

    // writeback from execute
    logic [WB_PORTS-1:0]                 wb_valid_in;
    logic [WB_PORTS*IDX-1:0]             wb_ptr_in;
    logic [WB_PORTS-1:0]                 wb_exc_in;

    // retire and redirect
    logic [COMMIT_WIDTH-1:0]             cmt_valid_out;
    logic [COMMIT_WIDTH*ADDR_BITS-1:0]   cmt_pc_out;
    logic [COMMIT_WIDTH*PREG_BITS-1:0]   cmt_dest_out;
    logic [COMMIT_WIDTH*PREG_BITS-1:0]   cmt_free_out;
    logic                                flush_out;
    logic [ADDR_BITS-1:0]                flush_pc_out;
    logic [IDX:0]                        count_out;

    modport master (
        output disp_valid_in, disp_pc_in, disp_dest_in, disp_old_dest_in,
        output wb_valid_in, wb_ptr_in, wb_exc_in,
        input  disp_ready_out, disp_ptr_out,
        input  cmt_valid_out, cmt_pc_out, cmt_dest_out, cmt_free_out,
        input  flush_out, flush_pc_out, count_out
    );

    modport slave (
        input  disp_valid_in, disp_pc_in, disp_dest_in, disp_old_dest_in,
        input  wb_valid_in, wb_ptr_in, wb_exc_in,
        output disp_ready_out, disp_ptr_out,
        output cmt_valid_out, cmt_pc_out, cmt_dest_out, cmt_free_out,
        output flush_out, flush_pc_out, count_out
    );
endinterface

// File: rtl/rob_queue.sv
// Reorder buffer: circular queue; dispatch up to DISPATCH_WIDTH, retire up to COMMIT_WIDTH oldest DONE entries in order.
// Latency: a writeback is seen by the commit scan the cycle after it lands; commit and flush outputs are registered (one edge after the scan).
// Backpressure: disp_ready_out low when fewer than DISPATCH_WIDTH slots free; dispatch while not ready or during flush is dropped.
module rob_queue #(
    parameter int ROB_ENTRIES    = 128,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int WB_PORTS       = 2,
    parameter int ADDR_BITS      = 64,
    parameter int PREG_BITS      = 7
) (
    input  logic       clk_in,
    input  logic       rst_N_in,
    rob_queue_if.slave rob
);
    localparam int IDX = $clog2(ROB_ENTRIES);
    localparam int PTR = IDX + 1;

    typedef enum logic [1:0] {ST_INVALID, ST_READY, ST_DONE, ST_EXC} status_e;

    status_e              status_q [ROB_ENTRIES];
    status_e              status_d [ROB_ENTRIES];
    logic [ADDR_BITS-1:0] pc_mem   [ROB_ENTRIES];
    logic [PREG_BITS-1:0] dest_mem [ROB_ENTRIES];
    logic [PREG_BITS-1:0] old_mem  [ROB_ENTRIES];

    // head/tail carry a wrap bit above the index so full and empty are distinguishable
    logic [PTR-1:0] head_q, head_d, tail_q, tail_d, count;
    logic [PTR-1:0] ndisp, ncmt;
    logic           disp_go, stop, exc_hit;
    logic [ADDR_BITS-1:0] exc_pc;

    logic [IDX-1:0] disp_idx [DISPATCH_WIDTH];
    logic [IDX-1:0] scan_idx [COMMIT_WIDTH];
    logic [IDX-1:0] wb_idx   [WB_PORTS];
    logic [DISPATCH_WIDTH*IDX-1:0] disp_ptr_all;

    logic [COMMIT_WIDTH-1:0]           cmt_vld_d, cmt_vld_q;
    logic [COMMIT_WIDTH*ADDR_BITS-1:0] cmt_pc_d, cmt_pc_q;
    logic [COMMIT_WIDTH*PREG_BITS-1:0] cmt_dest_d, cmt_dest_q;
    logic [COMMIT_WIDTH*PREG_BITS-1:0] cmt_free_d, cmt_free_q;
    logic                              flush_q;
    logic [ADDR_BITS-1:0]              flush_pc_q;

    assign count              = tail_q - head_q;
    assign rob.count_out      = count;
    // readiness uses registered occupancy only; commits this cycle are not credited
    assign rob.disp_ready_out = (PTR'(ROB_ENTRIES) - count) >= PTR'(DISPATCH_WIDTH);
    assign disp_go            = rob.disp_ready_out && !flush_q;

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_disp_idx
        assign disp_idx[k] = tail_q[IDX-1:0] + IDX'(k);
    end
    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_scan_idx
        assign scan_idx[i] = head_q[IDX-1:0] + IDX'(i);
    end
    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_idx
        assign wb_idx[p] = rob.wb_ptr_in[p*IDX +: IDX];
    end

    // pack per-lane slot indices for rename
    always_comb begin
        disp_ptr_all = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_ptr_all[k*IDX +: IDX] = disp_idx[k];
        end
    end
    assign rob.disp_ptr_out = disp_ptr_all;

    // number of lanes dispatching (lanes are contiguous from lane 0)
    always_comb begin
        ndisp = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            ndisp = ndisp + PTR'(rob.disp_valid_in[k]);
        end
    end

    // in-order scan from head: retire the DONE prefix, stop at an exception or anything else
    always_comb begin
        cmt_vld_d  = '0;
        cmt_pc_d   = '0;
        cmt_dest_d = '0;
        cmt_free_d = '0;
        ncmt       = '0;
        exc_hit    = 1'b0;
        exc_pc     = '0;
        stop       = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!stop) begin
                if (PTR'(i) >= count) begin
                    stop = 1'b1;
                end else if (status_q[scan_idx[i]] == ST_DONE) begin
                    cmt_vld_d[i]                          = 1'b1;
                    cmt_pc_d[i*ADDR_BITS +: ADDR_BITS]    = pc_mem[scan_idx[i]];
                    cmt_dest_d[i*PREG_BITS +: PREG_BITS]  = dest_mem[scan_idx[i]];
                    cmt_free_d[i*PREG_BITS +: PREG_BITS]  = old_mem[scan_idx[i]];
                    ncmt                                  = ncmt + PTR'(1);
                end else begin
                    if (status_q[scan_idx[i]] == ST_EXC) begin
                        exc_hit = 1'b1;
                        exc_pc  = pc_mem[scan_idx[i]];
                    end
                    stop = 1'b1;
                end
            end
        end
    end

    // entry status: writeback, then retire, then allocate; an exception squashes everything
    always_comb begin
        for (int e = 0; e < ROB_ENTRIES; e++) begin
            status_d[e] = status_q[e];
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (rob.wb_valid_in[p] && status_q[wb_idx[p]] != ST_INVALID) begin
                status_d[wb_idx[p]] = rob.wb_exc_in[p] ? ST_EXC : ST_DONE;
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (cmt_vld_d[i]) begin
                status_d[scan_idx[i]] = ST_INVALID;
            end
        end
        if (disp_go) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (rob.disp_valid_in[k]) begin
                    status_d[disp_idx[k]] = ST_READY;
                end
            end
        end
        if (exc_hit) begin
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                status_d[e] = ST_INVALID;
            end
        end
    end

    // pointer advance; a flush returns both pointers to zero
    always_comb begin
        head_d = head_q + ncmt;
        tail_d = disp_go ? (tail_q + ndisp) : tail_q;
        if (exc_hit) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    // control state and registered commit/flush outputs
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            cmt_vld_q  <= '0;
            cmt_pc_q   <= '0;
            cmt_dest_q <= '0;
            cmt_free_q <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                status_q[e] <= ST_INVALID;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cmt_vld_q  <= cmt_vld_d;
            cmt_pc_q   <= cmt_pc_d;
            cmt_dest_q <= cmt_dest_d;
            cmt_free_q <= cmt_free_d;
            flush_q    <= exc_hit;
            flush_pc_q <= exc_pc;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                status_q[e] <= status_d[e];
            end
        end
    end

    // payload is only read behind a valid status, so it needs no reset
    always_ff @(posedge clk_in) begin
        if (disp_go) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (rob.disp_valid_in[k]) begin
                    pc_mem[disp_idx[k]]   <= rob.disp_pc_in[k*ADDR_BITS +: ADDR_BITS];
                    dest_mem[disp_idx[k]] <= rob.disp_dest_in[k*PREG_BITS +: PREG_BITS];
                    old_mem[disp_idx[k]]  <= rob.disp_old_dest_in[k*PREG_BITS +: PREG_BITS];
                end
            end
        end
    end

    assign rob.cmt_valid_out = cmt_vld_q;
    assign rob.cmt_pc_out    = cmt_pc_q;
    assign rob.cmt_dest_out  = cmt_dest_q;
    assign rob.cmt_free_out  = cmt_free_q;
    assign rob.flush_out     = flush_q;
    assign rob.flush_pc_out  = flush_pc_q;
endmodule

// File: tb/tb_rob_queue.sv
// Bench for rob_queue: directed scenarios plus random traffic against a queue-based reference model.
// Latency: model predicts registered commit/flush outputs one edge after the scan.
// Backpressure: model drops dispatch when not ready or while flush is asserted.
module tb_rob_queue;
    localparam int ROB = 128;
    localparam int DW  = 2;
    localparam int CW  = 2;
    localparam int WBP = 2;
    localparam int AB  = 64;
    localparam int PB  = 7;
    localparam int IDX = 7;
    localparam int M_READY = 1;
    localparam int M_DONE  = 2;
    localparam int M_EXC   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_queue_if #(.ROB_ENTRIES(ROB), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW),
                   .WB_PORTS(WBP), .ADDR_BITS(AB), .PREG_BITS(PB)) rif ();

    rob_queue #(.ROB_ENTRIES(ROB), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW),
                .WB_PORTS(WBP), .ADDR_BITS(AB), .PREG_BITS(PB)) dut (
        .clk_in  (clk),
        .rst_N_in(rst_n),
        .rob     (rif)
    );

    // reference model: oldest-first list of live uops plus the slot number of the oldest
    typedef struct {
        logic [AB-1:0] pc;
        logic [PB-1:0] dest;
        logic [PB-1:0] old;
        int            st;
    } ment_t;

    ment_t         mq[$];
    int            m_hd;
    logic          exp_flush;
    logic [AB-1:0] exp_flush_pc;
    logic [CW-1:0] exp_cvld;
    logic [AB-1:0] exp_cpc   [CW];
    logic [PB-1:0] exp_cdest [CW];
    logic [PB-1:0] exp_cfree [CW];
    int total = 0;
    int bad   = 0;

    function automatic bit m_ready();
        return (ROB - mq.size()) >= DW;
    endfunction

    function automatic int m_ptr(input int k);
        return (m_hd + mq.size() + k) % ROB;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hd         = 0;
        exp_flush    = 1'b0;
        exp_flush_pc = '0;
        exp_cvld     = '0;
    endtask

    task automatic clear_inputs();
        rif.disp_valid_in    = '0;
        rif.disp_pc_in       = '0;
        rif.disp_dest_in     = '0;
        rif.disp_old_dest_in = '0;
        rif.wb_valid_in      = '0;
        rif.wb_ptr_in        = '0;
        rif.wb_exc_in        = '0;
    endtask

    task automatic set_disp(input int n, input logic [AB-1:0] base);
        for (int k = 0; k < DW; k++) begin
            rif.disp_valid_in[k]              = (k < n);
            rif.disp_pc_in[k*AB +: AB]        = base + AB'(4 * k);
            rif.disp_dest_in[k*PB +: PB]      = PB'($urandom);
            rif.disp_old_dest_in[k*PB +: PB]  = PB'($urandom);
        end
    endtask

    task automatic set_wb(input int p, input int ptr, input bit exc);
        rif.wb_valid_in[p]          = 1'b1;
        rif.wb_ptr_in[p*IDX +: IDX] = IDX'(ptr);
        rif.wb_exc_in[p]            = exc;
    endtask

    // complete up to nmax distinct not-yet-completed live uops
    task automatic pick_wb(input int exc_pct, input int nmax);
        int cand[$];
        int j;
        int pos;
        for (int i = 0; i < mq.size(); i++) if (mq[i].st == M_READY) cand.push_back(i);
        for (int p = 0; p < nmax && p < WBP && cand.size() > 0; p++) begin
            j   = $urandom_range(cand.size() - 1);
            pos = cand[j];
            cand.delete(j);
            set_wb(p, (m_hd + pos) % ROB, int'($urandom_range(99)) < exc_pct);
        end
    endtask

    // advance model by one edge using the currently driven inputs, then clock the DUT
    task automatic tick();
        bit            acc;
        bit            exc;
        logic [AB-1:0] epc;
        int            ncm;
        int            pos;
        ment_t         e;
        acc      = m_ready() && !exp_flush;
        exc      = 1'b0;
        epc      = '0;
        ncm      = 0;
        exp_cvld = '0;
        for (int i = 0; i < CW; i++) begin
            if (i >= mq.size()) break;
            if (mq[i].st == M_DONE) begin
                exp_cvld[i]  = 1'b1;
                exp_cpc[i]   = mq[i].pc;
                exp_cdest[i] = mq[i].dest;
                exp_cfree[i] = mq[i].old;
                ncm++;
            end else begin
                if (mq[i].st == M_EXC) begin
                    exc = 1'b1;
                    epc = mq[i].pc;
                end
                break;
            end
        end
        for (int p = 0; p < WBP; p++) begin
            if (rif.wb_valid_in[p]) begin
                pos = (int'(rif.wb_ptr_in[p*IDX +: IDX]) - m_hd + ROB) % ROB;
                if (pos < mq.size()) mq[pos].st = rif.wb_exc_in[p] ? M_EXC : M_DONE;
            end
        end
        for (int i = 0; i < ncm; i++) void'(mq.pop_front());
        m_hd = (m_hd + ncm) % ROB;
        if (acc) begin
            for (int k = 0; k < DW; k++) begin
                if (rif.disp_valid_in[k]) begin
                    e.pc   = rif.disp_pc_in[k*AB +: AB];
                    e.dest = rif.disp_dest_in[k*PB +: PB];
                    e.old  = rif.disp_old_dest_in[k*PB +: PB];
                    e.st   = M_READY;
                    mq.push_back(e);
                end
            end
        end
        if (exc) begin
            mq.delete();
            m_hd = 0;
        end
        exp_flush    = exc;
        exp_flush_pc = exc ? epc : '0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // complete everything live and let it retire, checking each commit pulse
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 400) begin
            clear_inputs();
            pick_wb(0, 2);
            tick();
            guard++;
            total++;
            if (rif.cmt_valid_out !== exp_cvld) begin
                bad++;
                $display("FAIL %s_cmt_valid got=%b want=%b", tag, rif.cmt_valid_out, exp_cvld);
            end
            for (int i = 0; i < CW; i++) begin
                if (exp_cvld[i]) begin
                    total++;
                    if (rif.cmt_pc_out[i*AB +: AB] !== exp_cpc[i] ||
                        rif.cmt_free_out[i*PB +: PB] !== exp_cfree[i]) begin
                        bad++;
                        $display("FAIL %s_cmt_lane%0d got pc=%h free=%h want pc=%h free=%h", tag, i,
                                 rif.cmt_pc_out[i*AB +: AB], rif.cmt_free_out[i*PB +: PB], exp_cpc[i], exp_cfree[i]);
                    end
                end
            end
        end
        clear_inputs();
        total++;
        if (mq.size() != 0 || rif.count_out !== 8'd0) begin
            bad++;
            $display("FAIL %s_drain_done got count=%0d model=%0d want 0", tag, rif.count_out, mq.size());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (rif.count_out !== 8'd0)      begin bad++; $display("FAIL rst_count got=%0d want=0", rif.count_out); end
        total++; if (rif.disp_ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", rif.disp_ready_out); end
        total++; if (rif.cmt_valid_out !== 2'b00) begin bad++; $display("FAIL rst_cmt got=%b want=00", rif.cmt_valid_out); end
        total++; if (rif.flush_out !== 1'b0)      begin bad++; $display("FAIL rst_flush got=%b want=0", rif.flush_out); end
        total++; if (rif.flush_pc_out !== 64'd0)  begin bad++; $display("FAIL rst_flush_pc got=%h want=0", rif.flush_pc_out); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        total++; if (rif.count_out !== 8'd0 || rif.cmt_valid_out !== 2'b00) begin
            bad++; $display("FAIL rst_idle got count=%0d cmt=%b want 0/00", rif.count_out, rif.cmt_valid_out);
        end
    endtask

    task automatic test_basic();
        do_reset();
        set_disp(2, 64'h100);
        total++; if (rif.disp_ptr_out[0 +: IDX] !== 7'd0 || rif.disp_ptr_out[IDX +: IDX] !== 7'd1) begin
            bad++; $display("FAIL basic_ptr got=%0d,%0d want=0,1", rif.disp_ptr_out[0 +: IDX], rif.disp_ptr_out[IDX +: IDX]);
        end
        tick();
        total++; if (rif.count_out !== 8'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", rif.count_out); end
        clear_inputs(); set_wb(0, 1, 1'b0); tick();
        total++; if (rif.cmt_valid_out !== 2'b00) begin bad++; $display("FAIL basic_wb1_nocmt got=%b want=00", rif.cmt_valid_out); end
        clear_inputs(); set_wb(1, 0, 1'b0); tick();
        total++; if (rif.cmt_valid_out !== 2'b00) begin bad++; $display("FAIL basic_wb0_nobypass got=%b want=00", rif.cmt_valid_out); end
        clear_inputs(); tick();
        total++; if (rif.cmt_valid_out !== 2'b11) begin bad++; $display("FAIL basic_cmt got=%b want=11", rif.cmt_valid_out); end
        total++; if (rif.cmt_pc_out[0 +: AB] !== 64'h100 || rif.cmt_pc_out[AB +: AB] !== 64'h104) begin
            bad++; $display("FAIL basic_cmt_pc got=%h,%h want=100,104", rif.cmt_pc_out[0 +: AB], rif.cmt_pc_out[AB +: AB]);
        end
        total++; if (rif.cmt_dest_out[0 +: PB] !== exp_cdest[0] || rif.cmt_free_out[PB +: PB] !== exp_cfree[1]) begin
            bad++; $display("FAIL basic_cmt_regs got dest0=%h free1=%h want %h %h",
                            rif.cmt_dest_out[0 +: PB], rif.cmt_free_out[PB +: PB], exp_cdest[0], exp_cfree[1]);
        end
        total++; if (rif.count_out !== 8'd0) begin bad++; $display("FAIL basic_count_after got=%0d want=0", rif.count_out); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 64; c++) begin
            set_disp(2, 64'h1000 + 64'(8 * c));
            tick();
        end
        clear_inputs();
        total++; if (rif.count_out !== 8'd128)   begin bad++; $display("FAIL fill_count got=%0d want=128", rif.count_out); end
        total++; if (rif.disp_ready_out !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", rif.disp_ready_out); end
        set_disp(2, 64'h9000);
        tick();
        total++; if (rif.count_out !== 8'd128 || rif.disp_ptr_out[0 +: IDX] !== 7'd0) begin
            bad++; $display("FAIL fill_drop got count=%0d ptr=%0d want 128/0", rif.count_out, rif.disp_ptr_out[0 +: IDX]);
        end
        drain("fill");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 64; c++) begin
            set_disp((c == 63) ? 1 : 2, 64'h2000 + 64'(8 * c));
            tick();
        end
        drain("prewrap");
        set_disp(2, 64'h3000);
        total++; if (rif.disp_ptr_out[0 +: IDX] !== 7'd127 || rif.disp_ptr_out[IDX +: IDX] !== 7'd0) begin
            bad++; $display("FAIL wrap_ptr got=%0d,%0d want=127,0", rif.disp_ptr_out[0 +: IDX], rif.disp_ptr_out[IDX +: IDX]);
        end
        tick();
        total++; if (rif.count_out !== 8'd2) begin bad++; $display("FAIL wrap_count got=%0d want=2", rif.count_out); end
        clear_inputs(); set_wb(0, 127, 1'b0); set_wb(1, 0, 1'b0); tick();
        clear_inputs(); tick();
        total++; if (rif.cmt_valid_out !== 2'b11 || rif.cmt_pc_out[0 +: AB] !== 64'h3000 || rif.cmt_pc_out[AB +: AB] !== 64'h3004) begin
            bad++; $display("FAIL wrap_cmt got vld=%b pc=%h,%h want 11 3000,3004",
                            rif.cmt_valid_out, rif.cmt_pc_out[0 +: AB], rif.cmt_pc_out[AB +: AB]);
        end
        total++; if (rif.count_out !== 8'd0) begin bad++; $display("FAIL wrap_count_after got=%0d want=0", rif.count_out); end
    endtask

    task automatic test_exception();
        do_reset();
        set_disp(2, 64'h200); tick();
        set_disp(2, 64'h208); tick();
        clear_inputs(); set_wb(0, 1, 1'b1); set_wb(1, 2, 1'b0); tick();
        clear_inputs(); set_wb(0, 3, 1'b0); set_wb(1, 0, 1'b0); tick();
        total++; if (rif.cmt_valid_out !== 2'b00 || rif.flush_out !== 1'b0) begin
            bad++; $display("FAIL exc_early got cmt=%b flush=%b want 00/0", rif.cmt_valid_out, rif.flush_out);
        end
        clear_inputs(); tick();
        total++; if (rif.cmt_valid_out !== 2'b01 || rif.cmt_pc_out[0 +: AB] !== 64'h200) begin
            bad++; $display("FAIL exc_older_cmt got vld=%b pc=%h want 01/200", rif.cmt_valid_out, rif.cmt_pc_out[0 +: AB]);
        end
        total++; if (rif.flush_out !== 1'b1 || rif.flush_pc_out !== 64'h204) begin
            bad++; $display("FAIL exc_flush got flush=%b pc=%h want 1/204", rif.flush_out, rif.flush_pc_out);
        end
        total++; if (rif.count_out !== 8'd0) begin bad++; $display("FAIL exc_count got=%0d want=0", rif.count_out); end
        clear_inputs(); set_wb(0, 3, 1'b0); set_disp(2, 64'h500); tick();
        total++; if (rif.count_out !== 8'd0 || rif.flush_out !== 1'b0 || rif.cmt_valid_out !== 2'b00) begin
            bad++; $display("FAIL exc_after got count=%0d flush=%b cmt=%b want 0/0/00", rif.count_out, rif.flush_out, rif.cmt_valid_out);
        end
        clear_inputs(); set_disp(2, 64'h600);
        total++; if (rif.disp_ptr_out[0 +: IDX] !== 7'd0) begin bad++; $display("FAIL exc_restart_ptr got=%0d want=0", rif.disp_ptr_out[0 +: IDX]); end
        tick();
        total++; if (rif.count_out !== 8'd2) begin bad++; $display("FAIL exc_restart_count got=%0d want=2", rif.count_out); end
        drain("postflush");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_disp(2, 64'h700 + 64'(8 * c));
            tick();
        end
        clear_inputs(); set_wb(0, 0, 1'b0); set_wb(1, 1, 1'b0); tick();
        clear_inputs(); tick();
        total++; if (rif.cmt_valid_out !== 2'b11 || rif.count_out !== 8'd10) begin
            bad++; $display("FAIL rmid_pre got cmt=%b count=%0d want 11/10", rif.cmt_valid_out, rif.count_out);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rif.cmt_valid_out !== 2'b00 || rif.count_out !== 8'd0 || rif.flush_out !== 1'b0) begin
            bad++; $display("FAIL rmid_async got cmt=%b count=%0d flush=%b want 00/0/0", rif.cmt_valid_out, rif.count_out, rif.flush_out);
        end
        do_reset();
        total++; if (rif.count_out !== 8'd0 || rif.disp_ready_out !== 1'b1) begin
            bad++; $display("FAIL rmid_release got count=%0d ready=%b want 0/1", rif.count_out, rif.disp_ready_out);
        end
    endtask

    task automatic test_random();
        int            n;
        bit            fill_phase;
        logic [AB-1:0] rpc;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_inputs();
            fill_phase = (cyc % 300) < 150;
            n   = fill_phase ? 2 : int'($urandom_range(DW));
            rpc = {$urandom, $urandom} & ~64'h3;
            set_disp(n, rpc);
            pick_wb(2, fill_phase ? (($urandom_range(3) == 0) ? 1 : 0) : 2);
            total++;
            if (rif.disp_ready_out !== m_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, rif.disp_ready_out, m_ready());
            end
            if (m_ready()) begin
                for (int k = 0; k < DW; k++) begin
                    total++;
                    if (int'(rif.disp_ptr_out[k*IDX +: IDX]) != m_ptr(k)) begin
                        bad++; $display("FAIL rnd_ptr cyc=%0d lane=%0d got=%0d want=%0d", cyc, k, rif.disp_ptr_out[k*IDX +: IDX], m_ptr(k));
                    end
                end
            end
            tick();
            total++;
            if (rif.cmt_valid_out !== exp_cvld) begin
                bad++; $display("FAIL rnd_cmt_valid cyc=%0d got=%b want=%b", cyc, rif.cmt_valid_out, exp_cvld);
            end
            for (int i = 0; i < CW; i++) begin
                if (exp_cvld[i]) begin
                    total++;
                    if (rif.cmt_pc_out[i*AB +: AB] !== exp_cpc[i] || rif.cmt_dest_out[i*PB +: PB] !== exp_cdest[i] ||
                        rif.cmt_free_out[i*PB +: PB] !== exp_cfree[i]) begin
                        bad++; $display("FAIL rnd_cmt_lane cyc=%0d lane=%0d got pc=%h d=%h f=%h want pc=%h d=%h f=%h", cyc, i,
                                        rif.cmt_pc_out[i*AB +: AB], rif.cmt_dest_out[i*PB +: PB], rif.cmt_free_out[i*PB +: PB],
                                        exp_cpc[i], exp_cdest[i], exp_cfree[i]);
                    end
                end
            end
            total++;
            if (rif.flush_out !== exp_flush || (exp_flush && rif.flush_pc_out !== exp_flush_pc)) begin
                bad++; $display("FAIL rnd_flush cyc=%0d got=%b/%h want=%b/%h", cyc, rif.flush_out, rif.flush_pc_out, exp_flush, exp_flush_pc);
            end
            total++;
            if (int'(rif.count_out) != mq.size()) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, rif.count_out, mq.size());
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_exception();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
